// File: rtl/display_scan_ctrl_if.sv
// Load bus and display outputs between the host, the scan controller and the digit mux.
// The master drives the load bus and reads the display outputs; the slave is the scan controller.
interface display_scan_ctrl_if;
  logic        load;
  logic [15:0] hexs_in;
  logic [3:0]  points_in;
  logic [3:0]  les_in;
  logic [3:0]  blink_en;
  logic [1:0]  scan;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  LEs;
  logic        frame_start;

  modport master (
    output load, hexs_in, points_in, les_in, blink_en,
    input  scan, hexs, points, LEs, frame_start
  );

  modport slave (
    input  load, hexs_in, points_in, les_in, blink_en,
    output scan, hexs, points, LEs, frame_start
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Digit-scan timing, frame-aligned display shadow registers and per-digit blinking
// for the 7-segment multiplexer.
module display_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                rst,
  display_scan_ctrl_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       scan_q, scan_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             frame_start_q, frame_start_d;

  logic             pend_valid_q, pend_valid_d;
  logic [15:0]      pend_hexs_q, pend_hexs_d;
  logic [3:0]       pend_points_q, pend_points_d;
  logic [3:0]       pend_les_q, pend_les_d;
  logic [3:0]       pend_blink_q, pend_blink_d;

  logic [15:0]      shadow_hexs_q, shadow_hexs_d;
  logic [3:0]       shadow_points_q, shadow_points_d;
  logic [3:0]       shadow_les_q, shadow_les_d;
  logic [3:0]       shadow_blink_q, shadow_blink_d;

  logic             tick;
  logic             fb;

  assign tick = (div_cnt_q == DIV_LAST);
  assign fb   = tick && (scan_q == 2'd3);

  always_comb begin
    div_cnt_d       = div_cnt_q + DIV_W'(1);
    scan_d          = scan_q;
    frame_cnt_d     = frame_cnt_q;
    blink_phase_d   = blink_phase_q;
    frame_start_d   = fb;
    pend_valid_d    = pend_valid_q;
    pend_hexs_d     = pend_hexs_q;
    pend_points_d   = pend_points_q;
    pend_les_d      = pend_les_q;
    pend_blink_d    = pend_blink_q;
    shadow_hexs_d   = shadow_hexs_q;
    shadow_points_d = shadow_points_q;
    shadow_les_d    = shadow_les_q;
    shadow_blink_d  = shadow_blink_q;

    if (tick) begin
      div_cnt_d = '0;
      scan_d    = scan_q + 2'd1;
    end

    if (bus.load) begin
      pend_valid_d  = 1'b1;
      pend_hexs_d   = bus.hexs_in;
      pend_points_d = bus.points_in;
      pend_les_d    = bus.les_in;
      pend_blink_d  = bus.blink_en;
    end

    // A load landing on the boundary itself bypasses the pending buffer.
    if (fb) begin
      pend_valid_d = 1'b0;
      if (bus.load) begin
        shadow_hexs_d   = bus.hexs_in;
        shadow_points_d = bus.points_in;
        shadow_les_d    = bus.les_in;
        shadow_blink_d  = bus.blink_en;
      end else if (pend_valid_q) begin
        shadow_hexs_d   = pend_hexs_q;
        shadow_points_d = pend_points_q;
        shadow_les_d    = pend_les_q;
        shadow_blink_d  = pend_blink_q;
      end

      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FRM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q       <= '0;
      scan_q          <= 2'd0;
      frame_cnt_q     <= '0;
      blink_phase_q   <= 1'b0;
      frame_start_q   <= 1'b0;
      pend_valid_q    <= 1'b0;
      pend_hexs_q     <= 16'h0000;
      pend_points_q   <= 4'h0;
      pend_les_q      <= 4'h0;
      pend_blink_q    <= 4'h0;
      shadow_hexs_q   <= 16'h0000;
      shadow_points_q <= 4'h0;
      shadow_les_q    <= 4'hF;
      shadow_blink_q  <= 4'h0;
    end else begin
      div_cnt_q       <= div_cnt_d;
      scan_q          <= scan_d;
      frame_cnt_q     <= frame_cnt_d;
      blink_phase_q   <= blink_phase_d;
      frame_start_q   <= frame_start_d;
      pend_valid_q    <= pend_valid_d;
      pend_hexs_q     <= pend_hexs_d;
      pend_points_q   <= pend_points_d;
      pend_les_q      <= pend_les_d;
      pend_blink_q    <= pend_blink_d;
      shadow_hexs_q   <= shadow_hexs_d;
      shadow_points_q <= shadow_points_d;
      shadow_les_q    <= shadow_les_d;
      shadow_blink_q  <= shadow_blink_d;
    end
  end

  assign bus.scan        = scan_q;
  assign bus.hexs        = shadow_hexs_q;
  assign bus.points      = shadow_points_q;
  assign bus.LEs         = shadow_les_q | (shadow_blink_q & {4{blink_phase_q}});
  assign bus.frame_start = frame_start_q;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Timing and buffering stage directly upstream of the 7-segment digit multiplexer.
- Divides the system clock into a digit-scan index `scan[1:0]` that the downstream mux uses for digit select.
- Holds the display contents (hex digits, decimal points, per-digit LE blank bits) in frame-aligned shadow registers, so updates never tear mid-frame.
- Adds per-digit blinking by forcing LE bits on a slow blink phase.

Parameters:
- SCAN_DIV, 100000, clock cycles per digit slot (must be >= 1).
- BLINK_FRAMES, 64, full 4-digit frames per blink half-period (must be >= 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe; captures hexs_in/points_in/les_in/blink_en.
- hexs_in  input  16  four hex digits; [3:0] is digit 0.
- points_in  input  4  decimal-point bits, bit i is digit i.
- les_in  input  4  LE bits, bit i is digit i; 1 = blank digit i.
- blink_en  input  4  bit i = 1 makes digit i blink.
- scan  output  2  current digit index 0..3, to the digit mux select.
- hexs  output  16  shadowed hex digits, to the mux.
- points  output  4  shadowed decimal points, to the mux.
- LEs  output  4  effective LE bits = shadow LE OR blink mask, to the mux.
- frame_start  output  1  one-cycle pulse in the cycle scan becomes 0 from 3.

Behaviour:
- Reset (rst=1 at clock edge), all registered:
  - div_cnt=0, scan=0, frame_cnt=0, blink_phase=0.
  - pending_valid=0, shadow hexs=16'h0000, shadow points=4'h0, shadow LEs=4'hF (all blanked), shadow blink=4'h0.
  - Outputs: scan=0, hexs=0, points=0, LEs=4'hF, frame_start=0.
  - rst overrides load and all counting in the same cycle.
  - Reset mid-frame discards any pending load.
- Divider:
  - div_cnt counts 0..SCAN_DIV-1.
  - tick is asserted when div_cnt==SCAN_DIV-1; at that edge div_cnt returns to 0.
  - SCAN_DIV=1: tick every cycle.
  - Divider width = clog2(SCAN_DIV), minimum 1 bit.
- Scan: on tick, scan <= scan+1 mod 4 (3 wraps to 0). scan is held otherwise.
- Frame boundary (fb) = tick && scan==3.
  - frame_start is registered: it is 1 in exactly the cycle after fb, i.e. the first cycle scan==0.
- Pending buffer:
  - load=1 copies all four inputs into pending registers and sets pending_valid.
  - A later load before a boundary overwrites pending (last write wins).
- Shadow update on fb:
  - If load=1 in the same cycle: shadows take the live inputs directly; pending_valid <= 0.
  - Else if pending_valid=1: shadows <= pending; pending_valid <= 0.
  - Else: shadows hold.
  - Shadows never change except on fb or rst.
- Blink:
  - On fb, frame_cnt increments.
  - When frame_cnt==BLINK_FRAMES-1 at fb, frame_cnt <= 0 and blink_phase toggles.
- LE output:
  - LEs = shadow_LEs | (shadow_blink & {4{blink_phase}}), combinational from registers.
  - A digit with blink set and LE=0 is visible for BLINK_FRAMES frames, then blanked for BLINK_FRAMES frames.
- Latency:
  - A load takes effect on outputs in the cycle after the next fb (0 to 4*SCAN_DIV cycles later).
  - scan changes exactly every SCAN_DIV cycles.
- Outputs are glitch-free registered values, except LEs, which is an OR of registers.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2):
- Reset release:
  - Outputs are scan=0, hexs=0, LEs=F.
  - scan sequence is 0,1,2,3,0, changing every 4 cycles.
  - First frame_start occurs 16 cycles after reset deassert.
- Mid-frame load (scan=1) of hexs_in=16'h1234, les_in=0, points_in=4'h5:
  - Outputs unchanged until scan wraps to 0.
  - Then hexs=1234, points=5, LEs=0, all in the same cycle frame_start=1.
- Two loads in one frame (16'hAAAA, then 16'h5555):
  - Only 5555 appears at the next boundary.
  - pending_valid is 0 afterwards; the next frame shows no change.
- load of 16'hBEEF coincident with the fb cycle:
  - hexs=BEEF in the very next cycle.
  - The boundary after that produces no further change.
- blink_en=4'b0001, les_in=0:
  - LEs[0] pattern over frames is 0,0,1,1,0,0 (toggling every 2 frames).
  - LEs[3:1] stay 0.
- Reset asserted at scan=2 with a load pending:
  - After reset: scan=0, LEs=F, hexs=0.
  - The pending data never appears.
